// File: rtl/uart_globals_pkg.sv
// Shared UART definitions: character geometry, receiver state encoding and
// parity-mode type, plus the parity check used by the receiver.
package uart_globals_pkg;

  localparam int unsigned CHAR_LENGTH  = 8;
  localparam int unsigned OVERSAMPLING = 16;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_rx_state_e;

  typedef enum logic {EVEN, ODD} uart_parity_e;

  // True when the data bits and the received parity bit disagree with the
  // configured parity sense.
  function automatic logic parity_error(input logic         data_xor,
                                        input logic         sampled,
                                        input uart_parity_e mode);
    return (data_xor ^ sampled) != (mode == ODD);
  endfunction

endpackage

// File: rtl/uart_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
module uart_sync_2ff #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RESET_VALUE;
      sync_q <= RESET_VALUE;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receive deserializer: oversamples rx on baud_tick, checks start,
// parity and stop bits, and presents characters on a valid/ready port.
module uart_rx_deserializer
  import uart_globals_pkg::*;
#(
  parameter int unsigned CHAR_LENGTH  = uart_globals_pkg::CHAR_LENGTH,
  parameter int unsigned OVERSAMPLING = uart_globals_pkg::OVERSAMPLING,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic                   pclk,
  input  logic                   areset,
  input  logic                   baud_tick,
  input  logic                   rx,
  output logic [CHAR_LENGTH-1:0] rx_data,
  output logic                   rx_valid,
  input  logic                   rx_ready,
  output logic                   parity_err,
  output logic                   framing_err,
  output logic                   overrun_err
);

  localparam int unsigned CNT_W = $clog2(OVERSAMPLING);
  localparam int unsigned BIT_W = $clog2(CHAR_LENGTH + 1);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLING / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(OVERSAMPLING - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(CHAR_LENGTH - 1);
  localparam uart_parity_e     PAR_MODE  = (PARITY_ODD != 0) ? ODD : EVEN;

  logic rx_s;

  uart_sync_2ff #(
    .RESET_VALUE(1'b1)
  ) u_rx_sync (
    .clk (pclk),
    .rst (areset),
    .d   (rx),
    .q   (rx_s)
  );

  uart_rx_state_e         state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [BIT_W-1:0]       bit_q, bit_d;
  logic [CHAR_LENGTH-1:0] shift_q, shift_d;
  logic                   perr_pend_q, perr_pend_d;
  logic                   prev_q, prev_d;

  logic [CHAR_LENGTH-1:0] data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;
  logic                   ovr_q, ovr_d;

  logic                   commit;
  logic                   commit_ferr;

  // Receive FSM: start validation, mid-bit sampling, parity and stop checks.
  // prev tracks rx_s on every tick, so after a low stop bit the line must be
  // seen high again before IDLE can detect another falling edge.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    perr_pend_d = perr_pend_q;
    prev_d      = prev_q;
    commit      = 1'b0;
    commit_ferr = 1'b0;
    if (baud_tick) begin
      prev_d = rx_s;
      unique case (state_q)
        IDLE: begin
          if (!rx_s && prev_q) begin
            cnt_d   = '0;
            state_d = START;
          end
        end
        START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_d = '0;
            if (rx_s) begin
              state_d = IDLE;
            end else begin
              bit_d       = '0;
              perr_pend_d = 1'b0;
              state_d     = DATA;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (cnt_q == FULL_LAST) begin
            cnt_d   = '0;
            shift_d = {rx_s, shift_q[CHAR_LENGTH-1:1]};
            bit_d   = bit_q + 1'b1;
            if (bit_q == LAST_BIT) begin
              state_d = (PARITY_EN != 0) ? PARITY : STOP;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        PARITY: begin
          if (cnt_q == FULL_LAST) begin
            cnt_d       = '0;
            perr_pend_d = parity_error(^shift_q, rx_s, PAR_MODE);
            state_d     = STOP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (cnt_q == FULL_LAST) begin
            cnt_d       = '0;
            commit      = 1'b1;
            commit_ferr = !rx_s;
            state_d     = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Output holding register: load on commit when the slot is free or being
  // drained this cycle, otherwise drop the new character and flag overrun.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    ovr_d   = 1'b0;
    if (commit) begin
      if (!valid_q || rx_ready) begin
        data_d  = shift_q;
        perr_d  = perr_pend_q;
        ferr_d  = commit_ferr;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge pclk or posedge areset) begin
    if (areset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      perr_pend_q <= 1'b0;
      prev_q      <= 1'b1;
      data_q      <= '0;
      valid_q     <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      perr_pend_q <= perr_pend_d;
      prev_q      <= prev_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      ovr_q       <= ovr_d;
    end
  end

  assign rx_data     = data_q;
  assign rx_valid    = valid_q;
  assign parity_err  = perr_q;
  assign framing_err = ferr_q;
  assign overrun_err = ovr_q;

endmodule

// File: doc/uart_rx_deserializer.md
# uart_rx_deserializer

Receive-side character deserializer that consumes the serial UART line and produces parallel characters of `CHAR_LENGTH` bits, the width defined in `uart_globals_pkg`. It sits directly downstream of the serial line and upstream of the receive FIFO or the monitor's character sink. It oversamples `rx` on an external baud tick, validates the start, parity and stop bits, and hands each character out on a valid/ready port with error flags.

## Interface
- `CHAR_LENGTH`, default `uart_globals_pkg::CHAR_LENGTH` (8): data bits per character, 5–9 legal.
- `OVERSAMPLING`, default 16: `baud_tick` pulses per bit period; even, ≥8.
- `PARITY_EN`, default 0: 1 = a parity bit follows the data bits.
- `PARITY_ODD`, default 0: 1 = odd parity, 0 = even; ignored when `PARITY_EN`=0.
- `pclk` in 1: the single clock; everything is synchronous to its rising edge.
- `areset` in 1: asynchronous, active-high reset.
- `baud_tick` in 1: one-`pclk` enable pulse, `OVERSAMPLING`× the baud rate.
- `rx` in 1: asynchronous serial input, idle high.
- `rx_data` out `CHAR_LENGTH`: received character, LSB = first bit received.
- `rx_valid` out 1: `rx_data` and the error flags are valid.
- `rx_ready` in 1: consumer accepts the character.
- `parity_err` out 1: parity mismatch on the presented character.
- `framing_err` out 1: stop bit sampled low on the presented character.
- `overrun_err` out 1: one-`pclk` pulse when a completed character is dropped.

## Operation
- `rx` passes through a 2-flop synchronizer, giving `rx_s`; the synchronizer resets to 1.
- FSM states: IDLE, START, DATA, PARITY, STOP. The FSM advances only on `baud_tick`.
- **IDLE:** on a `baud_tick` where `rx_s`=0 and the previous sampled value was 1 (a falling edge), clear the tick counter and go to START.
- **START:** after `OVERSAMPLING/2` ticks, sample `rx_s`.
  - 1: false start; go to IDLE and report nothing.
  - 0: clear the counter and go to DATA.
- **DATA:** sample every `OVERSAMPLING` ticks (mid-bit) and shift right into the shift register, LSB first. After `CHAR_LENGTH` samples, go to PARITY if `PARITY_EN`=1, otherwise to STOP.
- **PARITY:** sample once. The error condition is (XOR of data bits ^ sampled bit) != `PARITY_ODD`.
- **STOP:** sample once; 0 sets framing error. Then commit the character and go to IDLE.
- **Commit when `rx_valid`=0:** load `rx_data`, `parity_err` and `framing_err`, and set `rx_valid`.
- **Commit when `rx_valid`=1 and `rx_ready`=0:** drop the new character, pulse `overrun_err`, and leave the held outputs unchanged.
- **Commit when `rx_valid`=1 and `rx_ready`=1 in the same cycle:** the handshake completes and the new character loads. `rx_valid` stays 1 and there is no overrun.
- `rx_valid` falls on the cycle after `rx_valid && rx_ready` when no new character commits in that cycle.
- After a framing error, IDLE requires `rx_s`=1 to be sampled before it accepts a new falling edge (break condition). A break produces exactly one character and one `framing_err`.

## Timing
- Reset values:
  - `rx_data`=0, `rx_valid`=0, `parity_err`=0, `framing_err`=0, `overrun_err`=0.
  - FSM in IDLE, counters 0, previous-sample register 1.
- Reset assertion mid-character aborts the character immediately. Nothing is output afterwards.
- Latency, counted from the first `baud_tick` that sees `rx_s`=0: the stop sample falls on tick `OVERSAMPLING/2 + OVERSAMPLING*(CHAR_LENGTH + PARITY_EN + 1)`. With defaults and no parity this is tick 152.
- `rx_valid` rises on the `pclk` after that tick; the synchronizer adds 2 `pclk` of latency on `rx`.
- The FSM returns to IDLE in the middle of the stop bit, so a back-to-back start bit is detected with no lost character.
- `rx_data` and the flags are stable while `rx_valid`=1 and `rx_ready`=0.
- The tick counter width is `$clog2(OVERSAMPLING)`. The bit counter width is `$clog2(CHAR_LENGTH+1)`. Both wrap only by explicit clear.

## Structure
- Add to `uart_globals_pkg`:
  - `OVERSAMPLING` default (16).
  - `typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_rx_state_e`.
  - `typedef enum logic {EVEN, ODD} uart_parity_e`.
- One sub-module, `uart_sync_2ff`: a parameterized reset value, used for `rx`.
- The remaining logic (FSM, counters, shift register, output register) lives in this module.

## Test plan
- **Single character, defaults, `baud_tick` every 4 `pclk`:** send 0xA5 (8N1) with `rx_ready`=1 → `rx_data`=0xA5, `rx_valid` high for 1 cycle, all error flags 0, at tick 152.
- **Even parity, `PARITY_EN`=1:** send 0x07 with parity bit 0 → `parity_err`=1. Send 0x07 with parity bit 1 → `parity_err`=0.
- **Glitch:** a low pulse on `rx` lasting 3 ticks → no `rx_valid`, FSM back in IDLE. **Stop bit low:** send 0x3C with a low stop bit → `rx_data`=0x3C, `framing_err`=1.
- **Overrun:** hold `rx_ready`=0 and send 0x11 then 0x22 back-to-back → `rx_data` stays 0x11, `overrun_err` pulses once. Raise `rx_ready` → `rx_valid` falls next cycle.
- **Reset mid-character:** assert `areset` during data bit 4 of 0xFF → outputs 0 immediately. After release, 0x5A is received correctly.
- **Back-to-back stream:** 0x00, 0xFF, 0x55 with no idle gap → three characters in order, no errors.
